// File: rtl/tick_gen_pkg.sv
// Shared constants, channel action encoding and helpers
// for the multi-channel tick generator.
package tick_gen_pkg;

    localparam int NUM_CH_DEF    = 4;
    localparam int CNT_W_DEF     = 16;
    localparam int FREE_W_DEF    = 16;
    localparam int RESET_DIV_DEF = 2;

    // What a channel does on the coming edge, highest priority first
    typedef enum logic [1:0] {
        ACT_CLEAR,
        ACT_LOAD_NOW,
        ACT_LOAD_DEFER,
        ACT_COUNT
    } ch_act_e;

    // Width of the channel selector; never narrower than one bit
    function automatic int sel_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tick_channel.sv
// One divider channel: counter, active/shadow divisor,
// deferred-load flag, tick pulse and square output.
module tick_channel
    import tick_gen_pkg::*;
#(
    parameter int CNT_W     = CNT_W_DEF,
    parameter int RESET_DIV = RESET_DIV_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             sync_clear,
    input  logic             enable,
    input  logic             load,
    input  logic             load_immediate,
    input  logic [CNT_W-1:0] div_value,
    output logic             tick,
    output logic             square,
    output logic             load_pending
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] div;
    logic [CNT_W-1:0] shadow;
    logic [CNT_W-1:0] next_shadow;
    logic             next_pending;
    logic             run;
    logic             term;
    ch_act_e          act;

    // Pick this edge's action; a deferred load onto a halted
    // channel has nothing to wait for, so it is applied at once
    always_comb begin
        act = ACT_COUNT;
        if (sync_clear)
            act = ACT_CLEAR;
        else if (load && (load_immediate || div == '0))
            act = ACT_LOAD_NOW;
        else if (load)
            act = ACT_LOAD_DEFER;
    end

    assign run  = enable && (div != '0);
    assign term = (cnt == div - CNT_W'(1));

    // A write landing on the terminal-count edge is the newest
    // shadow value, so it is the one that takes effect there
    assign next_shadow  = (act == ACT_LOAD_DEFER) ? div_value : shadow;
    assign next_pending = (act == ACT_LOAD_DEFER) || load_pending;

    // Channel state update
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt          <= '0;
            div          <= CNT_W'(RESET_DIV);
            shadow       <= '0;
            load_pending <= 1'b0;
            tick         <= 1'b0;
            square       <= 1'b0;
        end else begin
            unique case (act)
                ACT_CLEAR: begin
                    cnt          <= '0;
                    tick         <= 1'b0;
                    square       <= 1'b0;
                    load_pending <= 1'b0;
                    if (load)
                        div <= div_value;
                    else if (load_pending)
                        div <= shadow;
                end
                ACT_LOAD_NOW: begin
                    cnt          <= '0;
                    tick         <= 1'b0;
                    div          <= div_value;
                    load_pending <= 1'b0;
                end
                ACT_LOAD_DEFER, ACT_COUNT: begin
                    shadow       <= next_shadow;
                    load_pending <= next_pending;
                    if (!run) begin
                        tick <= 1'b0;
                    end else if (term) begin
                        cnt    <= '0;
                        tick   <= 1'b1;
                        square <= ~square;
                        if (next_pending) begin
                            div          <= next_shadow;
                            load_pending <= 1'b0;
                        end
                    end else begin
                        cnt  <= cnt + CNT_W'(1);
                        tick <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/tick_generator.sv
// Free-running counter bus plus NUM_CH programmable
// clock-enable channels sharing one divisor write port.
module tick_generator
    import tick_gen_pkg::*;
#(
    parameter int NUM_CH    = NUM_CH_DEF,
    parameter int CNT_W     = CNT_W_DEF,
    parameter int FREE_W    = FREE_W_DEF,
    parameter int RESET_DIV = RESET_DIV_DEF
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         sync_clear,
    input  logic [NUM_CH-1:0]            ch_enable,
    input  logic                         div_load,
    input  logic [sel_width(NUM_CH)-1:0] div_sel,
    input  logic [CNT_W-1:0]             div_value,
    input  logic                         load_immediate,
    output logic [NUM_CH-1:0]            tick,
    output logic [NUM_CH-1:0]            square,
    output logic [NUM_CH-1:0]            load_pending,
    output logic [FREE_W-1:0]            divided_clocks
);

    logic [NUM_CH-1:0] load_vec;

    // Route the write strobe to one channel; out-of-range
    // selects match nothing and are dropped
    always_comb begin
        load_vec = '0;
        for (int i = 0; i < NUM_CH; i++)
            load_vec[i] = div_load && (32'(div_sel) == i);
    end

    // Free-running count, independent of channel enables
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            divided_clocks <= '0;
        else if (sync_clear)
            divided_clocks <= '0;
        else
            divided_clocks <= divided_clocks + FREE_W'(1);
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        tick_channel #(
            .CNT_W     (CNT_W),
            .RESET_DIV (RESET_DIV)
        ) u_ch (
            .clock          (clock),
            .reset          (reset),
            .sync_clear     (sync_clear),
            .enable         (ch_enable[g]),
            .load           (load_vec[g]),
            .load_immediate (load_immediate),
            .div_value      (div_value),
            .tick           (tick[g]),
            .square         (square[g]),
            .load_pending   (load_pending[g])
        );
    end

endmodule

// File: doc/tick_generator.md
Name: tick_generator

Overview:
Parametrised, multi-channel successor to the free-running divider. It keeps a free-running counter bus and adds NUM_CH independent channels. Each channel has a runtime-programmable divisor and produces a one-cycle clock-enable pulse and a 50%-duty square output. It sits beside the system clock and feeds the VGA pixel enable, game-logic update rate, paddle/ball speed and audio tone logic, with no derived clocks.

Parameters:
NUM_CH, 4, number of divider channels (1..16)
CNT_W, 16, width of each channel counter and divisor
FREE_W, 16, width of the free-running counter bus
RESET_DIV, 2, active divisor loaded into every channel at reset (must be < 2**CNT_W)

Ports:
clock  in  1  system clock; all state updates on its rising edge
reset  in  1  asynchronous, active-high reset
sync_clear  in  1  synchronous restart of all counters
ch_enable  in  NUM_CH  per-channel run enable
div_load  in  1  one-cycle divisor write strobe
div_sel  in  max(1,$clog2(NUM_CH))  channel targeted by div_load
div_value  in  CNT_W  new divisor N; 0 means halted
load_immediate  in  1  1 = apply now, 0 = defer to the channel's next terminal count
tick  out  NUM_CH  one-cycle pulse, once every N enabled cycles
square  out  NUM_CH  toggles on every tick; period 2N
load_pending  out  NUM_CH  deferred divisor waiting to be applied
divided_clocks  out  FREE_W  free-running count; +1 every cycle, wraps

Behaviour:
- Reset (async assert, sync release) sets:
  - divided_clocks = 0, each cnt = 0, tick = 0, square = 0
  - active div = RESET_DIV, shadow = 0, load_pending = 0
- divided_clocks: increments every edge and wraps 2**FREE_W-1 -> 0. It is unaffected by ch_enable and cleared only by reset or sync_clear.
- Per channel i, each edge, in priority order:
  1. sync_clear:
     - cnt = 0, tick = 0, square = 0.
     - Any pending shadow becomes active and load_pending clears.
     - A div_load to channel i in the same cycle is applied as immediate and overrides the shadow.
  2. div_load with div_sel == i and load_immediate = 1:
     - active div = div_value, cnt = 0, tick = 0, square held, load_pending = 0.
     - Beats a terminal count in the same cycle, so no tick is produced.
  3. div_load with div_sel == i and load_immediate = 0:
     - shadow = div_value, load_pending = 1; last write wins.
     - If the current active div == 0, it is applied on this edge as immediate.
     - Counting proceeds per step 4 in the same cycle.
  4. Counting:
     - If ch_enable[i] = 0 or active div == 0: cnt held, tick = 0.
     - Else if cnt == div-1 (terminal count): cnt = 0, tick = 1, square toggles. If load_pending, active div = shadow and load_pending = 0; that tick still belongs to the old divisor.
     - Else: cnt = cnt+1, tick = 0.
- Timing and widths:
  - Outputs are registered; no combinational path from inputs to outputs.
  - div = 1: tick is constantly high while enabled, and square toggles every cycle.
  - Counter arithmetic is unsigned CNT_W bits; the maximum divisor is 2**CNT_W-1.
- Selector and enable corner cases:
  - div_sel >= NUM_CH: the load is ignored and no state changes.
  - Deassertion of ch_enable freezes cnt and square; re-enable resumes from the held count.

Decomposition:
- Package tick_gen_pkg holds:
  - default constants: CNT_W_DEF = 16, RESET_DIV_DEF = 2
  - the channel-select width function: max(1, clog2(NUM_CH))
- Sub-module tick_channel contains one channel's cnt, active div, shadow, pending, tick and square logic.
- Top level: NUM_CH instances via generate, div_sel decode into per-channel load strobes, and the free-running counter.

Test Plan:
- Reset release, RESET_DIV = 2, all ch_enable = 1 -> tick on every channel high after edges 2, 4, 6…; square toggles at those edges; divided_clocks = 5 after 5 edges.
- Immediate load: channel 1 with div_value = 4, load_immediate = 1 -> ch1 tick exactly at edges load+4, +8…; tick period 4; square period 8; no tick on the load edge.
- Deferred load: channel 0 with div 5 to 3 mid-count at cnt = 2 -> load_pending = 1, next tick 2 cycles later at the old terminal count, then ticks every 3 cycles; load_pending = 0 after that tick.
- div_value = 0 on ch2 -> tick and square frozen for 100 cycles; then a deferred load of 1 -> applied next edge, tick high every cycle.
- Toggle ch_enable[3] low for 7 cycles at cnt = 1 (div 4) -> no ticks during the hold; the first tick comes 2 enabled cycles after re-enable.
- sync_clear with ch0 pending and a simultaneous immediate load of 6 -> all cnt/square = 0, divided_clocks = 0, ch0 div = 6; FREE_W = 4 wraps 15 -> 0.
